// File: rtl/pkg_npu_sched.sv
// Shared types for the NPU command scheduler: opcodes, FSM states and the default
// WAIT abort limit.
package pkg_npu_sched;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_OS    = 2'b01,
    OP_INTRA = 2'b10,
    OP_ILL   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP
  } state_e;

  localparam int DefTimeout = 4096;

  // Opcodes that launch work on the NPU controller and therefore expect op_done.
  function automatic logic op_is_exec(op_e op);
    return (op == OP_OS) || (op == OP_INTRA);
  endfunction

endpackage

// File: rtl/npu_cmd_fifo.sv
// Command FIFO with exact occupancy; a flush wins over a same-cycle push or pop,
// and pushes while full are silently dropped.
module npu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr, rd_ptr;
  logic [PtrW:0]    count;
  logic             push_ok, pop_ok;

  assign full_o  = (count == (PtrW+1)'(DEPTH));
  assign empty_o = (count == '0);
  assign count_o = count;
  assign data_o  = mem[rd_ptr];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (push_ok) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (PtrW+1)'(1);
        2'b01:   count <= count - (PtrW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem[wr_ptr] <= data_i;
  end

endmodule

// File: rtl/npu_cmd_scheduler.sv
// Pops queued commands and hands compute/transfer ops to the NPU controller one at
// a time, waiting for op_done (or a timeout) plus one settle cycle between ops.
module npu_cmd_scheduler
  import pkg_npu_sched::*;
#(
  parameter int DEPTH   = 4,
  parameter int KWidth  = 16,
  parameter int TIMEOUT = DefTimeout
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [KWidth-1:0]        cmd_k_i,
  input  logic                     flush_i,
  output logic                     op_start_o,
  output logic [1:0]               op_type_o,
  output logic [KWidth-1:0]        op_k_o,
  input  logic                     op_done_i,
  output logic                     busy_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [15:0]              done_cnt_o,
  output logic                     err_o
);

  localparam int CmdW  = 2 + KWidth;
  localparam int WaitW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CmdW-1:0]   fifo_head;
  logic              fifo_full, fifo_empty;
  op_e               head_op;
  logic [KWidth-1:0] head_k;
  logic              issue_valid, wait_expire;
  logic [WaitW-1:0]  wait_cnt_q;

  npu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CmdW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (cmd_valid_i),
    .data_i  ({cmd_op_i, cmd_k_i}),
    .pop_i   (state_q == ST_ISSUE),
    .flush_i (flush_i),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_o)
  );

  assign head_op     = op_e'(fifo_head[CmdW-1 -: 2]);
  assign head_k      = fifo_head[KWidth-1:0];
  // A flush during IDLE can empty the FIFO under an ISSUE already decided on.
  assign issue_valid = (state_q == ST_ISSUE) && !fifo_empty;
  assign wait_expire = (wait_cnt_q == WaitW'(TIMEOUT - 1));
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (state_q != ST_IDLE) || !fifo_empty;

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (!fifo_empty) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (issue_valid && op_is_exec(head_op)) ? ST_WAIT : ST_IDLE;
      ST_WAIT:  if (op_done_i || wait_expire) state_d = ST_GAP;
      ST_GAP:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_start_o <= 1'b0;
      op_type_o  <= 2'b00;
      op_k_o     <= '0;
      done_cnt_o <= '0;
      err_o      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      op_start_o <= 1'b0;
      if (issue_valid) begin
        if (op_is_exec(head_op)) begin
          op_start_o <= 1'b1;
          op_type_o  <= head_op;
          op_k_o     <= head_k;
        end
        if (head_op == OP_ILL) err_o <= 1'b1;
      end
      // Counter is zeroed on the way into WAIT, then counts WAIT cycles.
      if (state_q == ST_ISSUE)     wait_cnt_q <= '0;
      else if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + WaitW'(1);
      if (state_q == ST_WAIT) begin
        if (op_done_i)        done_cnt_o <= done_cnt_o + 16'd1;
        else if (wait_expire) err_o      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// Scoreboarded bench: pushes record the expected issue sequence, a monitor checks
// every start pulse, and a responder model answers with op_done after a chosen delay.
module tb_npu_cmd_scheduler;

  localparam int DEPTH = 4;
  localparam int KW    = 16;
  localparam int TO    = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [KW-1:0] cmd_k_i;
  logic          flush_i;
  logic          op_start_o;
  logic [1:0]    op_type_o;
  logic [KW-1:0] op_k_o;
  logic          op_done_i;
  logic          busy_o;
  logic [2:0]    fifo_count_o;
  logic [15:0]   done_cnt_o;
  logic          err_o;

  npu_cmd_scheduler #(
    .DEPTH   (DEPTH),
    .KWidth  (KW),
    .TIMEOUT (TO)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_k_i      (cmd_k_i),
    .flush_i      (flush_i),
    .op_start_o   (op_start_o),
    .op_type_o    (op_type_o),
    .op_k_o       (op_k_o),
    .op_done_i    (op_done_i),
    .busy_o       (busy_o),
    .fifo_count_o (fifo_count_o),
    .done_cnt_o   (done_cnt_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]    op;
    logic [KW-1:0] k;
  } issue_t;

  issue_t exp_q[$];
  int     resp_q[$];
  int     exp_done;
  bit     exp_err;
  int     n_cmp = 0;
  int     n_fail = 0;
  int     resp_d;
  issue_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Push one command; accepted legal ops join the expected issue order with their
  // responder delay (-1 = controller never answers, so the scheduler must time out).
  task automatic push(input logic [1:0] op, input logic [KW-1:0] k, input int d, input bit accept);
    issue_t e;
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_k_i     = k;
    @(posedge clk_i);
    #1;
    cmd_valid_i = 1'b0;
    if (accept) begin
      if (op == 2'b01 || op == 2'b10) begin
        e.op = op;
        e.k  = k;
        exp_q.push_back(e);
        resp_q.push_back(d);
        if (d >= 0 && d < TO) exp_done++;
        else                  exp_err = 1'b1;
      end else if (op == 2'b11) begin
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int i;
    i = 0;
    @(negedge clk_i);
    while (busy_o && i < 3000) begin
      @(negedge clk_i);
      i++;
    end
    if (busy_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: busy_o got 1 after 3000 cycles, expected 0", name);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, op_start_o, 0);
    check({tag, "_type"},  op_type_o, 0);
    check({tag, "_k"},     op_k_o, 0);
    check({tag, "_done"},  done_cnt_o, 0);
    check({tag, "_err"},   err_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_count"}, fifo_count_o, 0);
    check({tag, "_ready"}, cmd_ready_o, 1);
  endtask

  task automatic model_reset();
    exp_q.delete();
    resp_q.delete();
    exp_done = 0;
    exp_err  = 1'b0;
  endtask

  // Scoreboard monitor: every start pulse must match the next expected issue.
  initial begin
    forever begin
      @(negedge clk_i);
      if (op_start_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_start: got type %0d k 0x%0h, expected no start", op_type_o, op_k_o);
        end else begin
          mon_e = exp_q.pop_front();
          check("start_type", op_type_o, mon_e.op);
          check("start_k", op_k_o, mon_e.k);
        end
      end
    end
  end

  // Controller model: raises op_done_i during WAIT cycle d after the start pulse.
  initial begin
    op_done_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (op_start_o === 1'b1) begin
        resp_d = (resp_q.size() > 0) ? resp_q.pop_front() : -1;
        if (resp_d >= 0) begin
          repeat (resp_d) @(negedge clk_i);
          op_done_i = 1'b1;
          @(negedge clk_i);
          op_done_i = 1'b0;
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at 2ms, expected completion");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_op_i    = 2'b00;
    cmd_k_i     = '0;
    flush_i     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_reset_vals("rst");
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single OS op: start exactly two edges after the push edge.
    push(2'b01, 16'd16, 20, 1'b1);
    @(negedge clk_i); check("lat_t0", op_start_o, 0);
    @(negedge clk_i); check("lat_t1", op_start_o, 0);
    @(negedge clk_i); check("lat_t2", op_start_o, 1);
    check("lat_busy", busy_o, 1);
    wait_idle("single_op");
    check("single_done", done_cnt_o, exp_done);
    check("single_err", err_o, 0);

    // Fill the FIFO while the scheduler sits in WAIT; the fifth push is dropped.
    push(2'b01, 16'h0101, 40, 1'b1);
    repeat (3) @(negedge clk_i);
    check("full_started", op_start_o, 1);
    for (int i = 0; i < DEPTH; i++) push(2'b10, KW'(16'h0200 + i), i, 1'b1);
    @(negedge clk_i);
    check("full_count", fifo_count_o, DEPTH);
    check("full_ready", cmd_ready_o, 0);
    push(2'b01, 16'hDEAD, 0, 1'b0);
    @(negedge clk_i);
    check("full_drop_count", fifo_count_o, DEPTH);
    wait_idle("full");
    check("full_done", done_cnt_o, exp_done);

    // Timeout: controller never answers; the queued command still issues afterwards.
    push(2'b01, 16'd7, -1, 1'b1);
    repeat (3) @(negedge clk_i);
    check("to_started", op_start_o, 1);
    push(2'b10, 16'd5, 2, 1'b1);
    repeat (TO - 1) @(negedge clk_i);
    check("to_err_before", err_o, 0);
    @(negedge clk_i);
    check("to_err_after", err_o, 1);
    check("to_queued", fifo_count_o, 1);
    wait_idle("timeout");
    check("to_done", done_cnt_o, exp_done);
    check("to_err_sticky", err_o, exp_err);

    // Reset in the middle of WAIT; the late op_done must not count.
    push(2'b01, 16'd3, 50, 1'b1);
    repeat (3) @(negedge clk_i);
    check("rstw_started", op_start_o, 1);
    repeat (10) @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    check_reset_vals("rstw");
    rst_ni = 1'b1;
    model_reset();
    repeat (60) @(negedge clk_i);
    check("rstw_done_ignored", done_cnt_o, 0);
    check("rstw_idle", busy_o, 0);

    // Flush with a simultaneous push while an op is in flight.
    push(2'b01, 16'd9, 30, 1'b1);
    repeat (3) @(negedge clk_i);
    check("fl_started", op_start_o, 1);
    push(2'b01, 16'h0011, 1, 1'b1);
    push(2'b10, 16'h0022, 1, 1'b1);
    push(2'b01, 16'h0033, 1, 1'b1);
    @(negedge clk_i);
    check("fl_count_pre", fifo_count_o, 3);
    flush_i     = 1'b1;
    cmd_valid_i = 1'b1;
    cmd_op_i    = 2'b01;
    cmd_k_i     = 16'h0099;
    @(posedge clk_i);
    #1;
    flush_i     = 1'b0;
    cmd_valid_i = 1'b0;
    exp_q.delete();
    resp_q.delete();
    exp_done = exp_done - 3;
    @(negedge clk_i);
    check("fl_count_post", fifo_count_o, 0);
    check("fl_ready", cmd_ready_o, 1);
    check("fl_busy", busy_o, 1);
    wait_idle("flush");
    check("fl_done", done_cnt_o, exp_done);
    check("fl_err", err_o, 0);

    // Mixed sequence: OS, INTRA, NOP, illegal.
    push(2'b01, 16'd8, 2, 1'b1);
    push(2'b10, 16'd0, 1, 1'b1);
    push(2'b00, 16'h0055, 0, 1'b1);
    push(2'b11, 16'h0066, 0, 1'b1);
    wait_idle("mixed");
    check("mix_done", done_cnt_o, exp_done);
    check("mix_err", err_o, exp_err);
    check("mix_type_held", op_type_o, 2'b10);
    check("mix_k_held", op_k_o, 0);

    // Randomized bursts, each drained before the next.
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    @(negedge clk_i);
    check("rnd_reset_done", done_cnt_o, 0);
    for (int b = 0; b < 12; b++) begin
      int n;
      n = $urandom_range(DEPTH, 1);
      for (int j = 0; j < n; j++) begin
        logic [1:0]    op;
        logic [KW-1:0] k;
        int            d;
        op = 2'($urandom_range(3, 0));
        k  = KW'($urandom);
        d  = ($urandom_range(9, 0) == 0) ? -1 : int'($urandom_range(8, 0));
        push(op, k, d, 1'b1);
        repeat ($urandom_range(2, 0)) @(negedge clk_i);
      end
      wait_idle("rnd_burst");
      check("rnd_done", done_cnt_o, exp_done);
      check("rnd_err", err_o, exp_err);
      check("rnd_count", fifo_count_o, 0);
      check("rnd_all_issued", exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
